clint: RTL
==========

Name: clint

Overview:
- Core-local interrupt/exception sequencer that sits directly upstream of ctrl and drives its hold_flag_clint_i input.
- Detects ECALL/EBREAK in the decode-stage instruction, external async interrupts and MRET.
- Writes mepc/mcause/mstatus to the CSR file in a fixed multi-cycle sequence.
- Then issues a one-cycle redirect (int_assert_o/int_addr_o) to ex/pc_reg.

Parameters:
- INT_W, 8, width of int_flag_i.
- ASYNC_CAUSE, 32'h8000_0007, mcause value written for any async interrupt.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- inst_i  in  32  instruction currently in id.
- inst_addr_i  in  32  PC of inst_i.
- jump_flag_i  in  1  ex is redirecting this cycle.
- jump_addr_i  in  32  ex redirect target.
- div_started_i  in  1  multi-cycle divide in flight.
- int_flag_i  in  INT_W  external interrupt lines, level.
- csr_mtvec_i  in  32  current mtvec.
- csr_mepc_i  in  32  current mepc.
- csr_mstatus_i  in  32  current mstatus.
- we_o  out  1  CSR write enable.
- waddr_o  out  32  CSR address (0x341 mepc, 0x342 mcause, 0x300 mstatus).
- data_o  out  32  CSR write data.
- hold_flag_o  out  1  pipeline hold request to ctrl.
- int_assert_o  out  1  one-cycle redirect strobe.
- int_addr_o  out  32  redirect target.

Behaviour:
- Reset: state S_IDLE; all outputs 0; cause_q, epc_q = 0.
- Sync detection (S_IDLE only):
  - inst_i == 32'h0000_0073 -> cause 11.
  - inst_i == 32'h0010_0073 -> cause 3.
  - epc = inst_addr_i.
- Async detection (S_IDLE only): |int_flag_i && csr_mstatus_i[3] && !div_started_i -> cause ASYNC_CAUSE.
  - epc = jump_flag_i ? jump_addr_i : inst_addr_i.
  - If div_started_i is high, the request is deferred and re-evaluated each cycle; no latching.
- MRET: inst_i == 32'h3020_0073.
- Priority: sync > async > MRET. Only one event is accepted per entry into S_IDLE.
- States:
  - S_IDLE -> S_MEPC on exception or interrupt; latch cause_q and epc_q.
  - S_IDLE -> S_MRET on MRET.
  - S_MEPC: we=1, waddr=0x341, data=epc_q. Next S_MCAUSE.
  - S_MCAUSE: we=1, waddr=0x342, data=cause_q. Next S_MSTATUS.
  - S_MSTATUS: we=1, waddr=0x300, data=csr_mstatus_i with bit7 (MPIE) = bit3 (MIE) and bit3 = 0. Next S_ASSERT.
  - S_ASSERT: int_assert_o=1, int_addr_o = trap target. Next S_IDLE.
  - S_MRET: we=1, waddr=0x300, data=csr_mstatus_i with bit3 = bit7 and bit7 = 1. Next S_MRET_ASSERT.
  - S_MRET_ASSERT: int_assert_o=1, int_addr_o = csr_mepc_i. Next S_IDLE.
- Registered outputs: we_o/waddr_o/data_o/int_assert_o/int_addr_o are registered. Each value appears the cycle after the state is entered and is 0 in every other cycle.
- hold_flag_o is combinational:
  - 1 whenever state != S_IDLE.
  - 1 in S_IDLE during the detection cycle.
- Latencies:
  - Trap: detect to int_assert_o = 5 cycles.
  - MRET: detect to int_assert_o = 3 cycles.
- Boundary rules:
  - Async lines are ignored while not in S_IDLE.
  - MIE is cleared before return to S_IDLE, so no re-entry occurs until MRET.
  - Reset mid-sequence aborts immediately, with no partial redirect.

Optional Feature:
- Macro CLINT_VECTORED_EN.
- Defined: if csr_mtvec_i[1:0] == 2'b01 and the event is async, trap target = {mtvec[31:2],2'b00} + (cause_q[30:0] << 2). Sync traps still go to base.
- Undefined: trap target is always {mtvec[31:2],2'b00}, and mode bits are ignored.

Decomposition:
- Shared package holds:
  - state enum;
  - CSR address constants (mepc/mcause/mstatus/mtvec);
  - encodings for ECALL, EBREAK, MRET;
  - cause constants;
  - MIE/MPIE bit indices.
- No sub-module: a single FSM module is the natural granularity.

Test Plan:
- ECALL at inst_addr 0x100, mtvec 0x200, mstatus 0x8:
  - writes 0x341=0x100, 0x342=11, 0x300=0x80 on consecutive cycles;
  - then int_assert with addr 0x200;
  - hold high for 5 cycles.
- int_flag=0x01, mstatus.MIE=1, jump_flag=1, jump_addr=0x400:
  - mepc=0x400, mcause=0x8000_0007;
  - redirect to the mtvec base.
- int_flag=0x01 with div_started=1 for 3 cycles, then 0: no hold during the divide; the sequence starts on the cycle div_started drops.
- MRET with mstatus=0x80, mepc=0x104: writes mstatus=0x88, then int_assert with addr 0x104, 3-cycle hold.
- ECALL and int_flag both set in the same cycle: mcause=11 (sync wins); async is not taken until MIE is restored.
- With CLINT_VECTORED_EN, mtvec=0x201, async cause 7: redirect 0x21C. rst_n_i pulsed during S_MCAUSE gives all outputs 0 and no int_assert.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared types and constants for the core-local interrupt/exception sequencer.
package clint_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMepc,
    StMcause,
    StMstatus,
    StAssert,
    StMret,
    StMretAssert
  } state_e;

  localparam logic [31:0] CsrMepc    = 32'h0000_0341;
  localparam logic [31:0] CsrMcause  = 32'h0000_0342;
  localparam logic [31:0] CsrMstatus = 32'h0000_0300;
  localparam logic [31:0] CsrMtvec   = 32'h0000_0305;

  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstMret   = 32'h3020_0073;

  localparam logic [31:0] CauseEcall  = 32'd11;
  localparam logic [31:0] CauseEbreak = 32'd3;

  localparam int unsigned MieBit  = 3;
  localparam int unsigned MpieBit = 7;

  function automatic logic [31:0] trap_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/clint.sv
// Trap/interrupt sequencer: writes mepc/mcause/mstatus, then redirects the pipeline.
// Optional macro CLINT_VECTORED_EN enables vectored mode for async interrupts.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned INT_W       = 8,
  parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0007
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_started_i,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      data_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, epc_q;
  logic        idle, sync_ev, async_ev, mret_ev;
  logic [31:0] sync_cause;
  logic [31:0] trap_addr;

  logic        we_d, assert_d;
  logic [31:0] waddr_d, data_d, addr_d;

  assign idle       = (state_q == StIdle);
  assign sync_ev    = idle && ((inst_i == InstEcall) || (inst_i == InstEbreak));
  assign sync_cause = (inst_i == InstEcall) ? CauseEcall : CauseEbreak;
  // A divide in flight defers the interrupt; it is re-evaluated every cycle.
  assign async_ev   = idle && !sync_ev && (|int_flag_i) && csr_mstatus_i[MieBit] &&
                      !div_started_i;
  assign mret_ev    = idle && !sync_ev && !async_ev && (inst_i == InstMret);

  assign hold_flag_o = !idle || sync_ev || async_ev || mret_ev;

`ifdef CLINT_VECTORED_EN
  always_comb begin
    trap_addr = trap_base(csr_mtvec_i);
    if ((csr_mtvec_i[1:0] == 2'b01) && cause_q[31]) begin
      trap_addr = trap_base(csr_mtvec_i) + {cause_q[29:0], 2'b00};
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^csr_mtvec_i[1:0];
  assign trap_addr   = trap_base(csr_mtvec_i);
`endif

  // State register plus the trap context latched on acceptance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (sync_ev) begin
        cause_q <= sync_cause;
        epc_q   <= inst_addr_i;
      end else if (async_ev) begin
        cause_q <= ASYNC_CAUSE;
        epc_q   <= jump_flag_i ? jump_addr_i : inst_addr_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sync_ev || async_ev) begin
          state_d = StMepc;
        end else if (mret_ev) begin
          state_d = StMret;
        end
      end
      StMepc:       state_d = StMcause;
      StMcause:     state_d = StMstatus;
      StMstatus:    state_d = StAssert;
      StAssert:     state_d = StIdle;
      StMret:       state_d = StMretAssert;
      StMretAssert: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d     = 1'b0;
    waddr_d  = '0;
    data_d   = '0;
    assert_d = 1'b0;
    addr_d   = '0;
    unique case (state_q)
      StMepc: begin
        we_d    = 1'b1;
        waddr_d = CsrMepc;
        data_d  = epc_q;
      end
      StMcause: begin
        we_d    = 1'b1;
        waddr_d = CsrMcause;
        data_d  = cause_q;
      end
      StMstatus: begin
        we_d            = 1'b1;
        waddr_d         = CsrMstatus;
        data_d          = csr_mstatus_i;
        data_d[MpieBit] = csr_mstatus_i[MieBit];
        data_d[MieBit]  = 1'b0;
      end
      StAssert: begin
        assert_d = 1'b1;
        addr_d   = trap_addr;
      end
      StMret: begin
        we_d            = 1'b1;
        waddr_d         = CsrMstatus;
        data_d          = csr_mstatus_i;
        data_d[MieBit]  = csr_mstatus_i[MpieBit];
        data_d[MpieBit] = 1'b1;
      end
      StMretAssert: begin
        assert_d = 1'b1;
        addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      we_o         <= we_d;
      waddr_o      <= waddr_d;
      data_o       <= data_d;
      int_assert_o <= assert_d;
      int_addr_o   <= addr_d;
    end
  end

endmodule
